// File: rtl/pwr_pkg.sv
// Shared definitions for the rail power sequencer: state encoding, default timing, retry limit.
// Pure declarations; no latency or flow control of its own.
package pwr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF      = 3'd0;
  localparam state_t ST_RAMP     = 3'd1;
  localparam state_t ST_SETTLE   = 3'd2;
  localparam state_t ST_RUN      = 3'd3;
  localparam state_t ST_SHUTDOWN = 3'd4;
  localparam state_t ST_FAULT    = 3'd5;

  localparam int DEF_NUM_RAILS      = 4;
  localparam int DEF_STAGGER_CYCLES = 50000;
  localparam int DEF_SETTLE_CYCLES  = 500000;
  localparam int RETRY_LIMIT        = 3;

  // Index of the lowest 0 bit; unused upper bits are expected to be padded with 1.
  function automatic logic [2:0] lowest_zero(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module pwr_seq_timer #(
  parameter int TW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Staggered power-rail sequencer with latched fault; outputs registered, one edge after inputs.
// No backpressure (level inputs). Optional automatic fault retry under PWR_SEQ_AUTO_RETRY_EN.
module pwr_seq_ctrl
  import pwr_pkg::*;
#(
  parameter int NUM_RAILS      = DEF_NUM_RAILS,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ack,
  input  logic [NUM_RAILS-1:0] rail_ok,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 ready,
  output logic                 fault,
  output logic [2:0]           fault_rail,
  output logic [2:0]           state
);

  localparam int TMAX = (STAGGER_CYCLES > SETTLE_CYCLES) ? STAGGER_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  // Loading N-1 makes the timed action land exactly N edges after the load edge.
  localparam logic [TW-1:0] STAG_LD = TW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0] SETL_LD = TW'(SETTLE_CYCLES - 1);

  state_t                 state_n;
  logic [NUM_RAILS-1:0]   rail_n;
  logic                   ready_n, fault_n;
  logic [2:0]             frail_n;
  logic                   tmr_load, tmr_done, do_shut;
  logic [TW-1:0]          tmr_val;
  logic [7:0]             ok_pad;

`ifdef PWR_SEQ_AUTO_RETRY_EN
  logic [1:0] retry_cnt, retry_n;
  logic [1:0] phase, phase_n;
`endif

  pwr_seq_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    ok_pad = '1;
    ok_pad[NUM_RAILS-1:0] = rail_ok;
  end

  always_comb begin
    state_n  = state;
    rail_n   = rail_en;
    ready_n  = ready;
    fault_n  = fault;
    frail_n  = fault_rail;
    tmr_load = 1'b0;
    tmr_val  = STAG_LD;
    do_shut  = 1'b0;
`ifdef PWR_SEQ_AUTO_RETRY_EN
    retry_n  = retry_cnt;
    phase_n  = phase;
`endif
    case (state)
      ST_OFF: begin
        if (start) begin
          rail_n   = NUM_RAILS'(1);
          state_n  = ST_RAMP;
          tmr_load = 1'b1;
        end
      end
      ST_RAMP: begin
        if (!start) begin
          do_shut = 1'b1;
        end else if (tmr_done) begin
          rail_n   = {rail_en[NUM_RAILS-2:0], 1'b1};
          tmr_load = 1'b1;
          if (rail_en[NUM_RAILS-2]) begin
            state_n = ST_SETTLE;
            tmr_val = SETL_LD;
          end
        end
      end
      ST_SETTLE: begin
        if (!start) begin
          do_shut = 1'b1;
        end else if (tmr_done) begin
          state_n  = ST_RUN;
          ready_n  = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_RUN: begin
        // A rail fault outranks a simultaneous power-down request.
        if (!(&rail_ok)) begin
          fault_n = 1'b1;
          frail_n = lowest_zero(ok_pad);
          do_shut = 1'b1;
        end else if (!start) begin
          do_shut = 1'b1;
        end
      end
      ST_SHUTDOWN: begin
        if (tmr_done) do_shut = 1'b1;
      end
      ST_FAULT: begin
        if (ack) begin
          fault_n  = 1'b0;
          frail_n  = '0;
          state_n  = ST_OFF;
          tmr_load = 1'b1;
`ifdef PWR_SEQ_AUTO_RETRY_EN
          retry_n  = '0;
        end else if (tmr_done) begin
          // Four settle periods are counted in phases so the timer stays settle-sized.
          if (phase != 2'd3) begin
            phase_n  = phase + 2'd1;
            tmr_load = 1'b1;
            tmr_val  = SETL_LD;
          end else if (start && (retry_cnt < 2'(RETRY_LIMIT))) begin
            retry_n  = retry_cnt + 2'd1;
            fault_n  = 1'b0;
            frail_n  = '0;
            state_n  = ST_OFF;
            tmr_load = 1'b1;
          end
`endif
        end
      end
      default: state_n = ST_OFF;
    endcase

    // Drop the highest rail; leaving the last one off ends the shutdown.
    if (do_shut) begin
      rail_n   = rail_en >> 1;
      ready_n  = 1'b0;
      tmr_load = 1'b1;
      if (rail_en[1]) begin
        state_n = ST_SHUTDOWN;
        tmr_val = STAG_LD;
      end else begin
        state_n = fault_n ? ST_FAULT : ST_OFF;
        tmr_val = SETL_LD;
`ifdef PWR_SEQ_AUTO_RETRY_EN
        phase_n = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_OFF;
      rail_en    <= '0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
`ifdef PWR_SEQ_AUTO_RETRY_EN
      retry_cnt  <= '0;
      phase      <= '0;
`endif
    end else begin
      state      <= state_n;
      rail_en    <= rail_n;
      ready      <= ready_n;
      fault      <= fault_n;
      fault_rail <= frail_n;
`ifdef PWR_SEQ_AUTO_RETRY_EN
      retry_cnt  <= retry_n;
      phase      <= phase_n;
`endif
    end
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed vector bench for pwr_seq_ctrl with short stagger/settle times.
// Each row: drive inputs, advance a number of edges, compare all outputs.
module tb_pwr_seq_ctrl;
  import pwr_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, ack;
  logic [3:0] rail_ok, rail_en;
  logic       ready, fault;
  logic [2:0] fault_rail, state;

  int checks = 0;
  int errors = 0;

  pwr_seq_ctrl #(.NUM_RAILS(4), .STAGGER_CYCLES(8), .SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ack        (ack),
    .rail_ok    (rail_ok),
    .rail_en    (rail_en),
    .ready      (ready),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, ak;
    logic [3:0] ok;
    int         adv;
    logic [3:0] en;
    logic       rdy, flt;
    logic [2:0] frail;
    logic [2:0] sta;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic st, logic ak, logic [3:0] ok, int adv,
                              logic [3:0] en, logic rdy, logic flt, logic [2:0] frail,
                              logic [2:0] sta);
    vec_t v;
    v.rst = rst; v.st = st; v.ak = ak; v.ok = ok; v.adv = adv;
    v.en = en; v.rdy = rdy; v.flt = flt; v.frail = frail; v.sta = sta;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] en, logic rdy, logic flt,
                       logic [2:0] frail, logic [2:0] sta);
    checks++;
    if (rail_en !== en || ready !== rdy || fault !== flt || fault_rail !== frail || state !== sta) begin
      errors++;
      $display("FAIL %s: got en=%b rdy=%b flt=%b frail=%0d st=%0d, want en=%b rdy=%b flt=%b frail=%0d st=%0d",
               name, rail_en, ready, fault, fault_rail, state, en, rdy, flt, frail, sta);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; rail_ok = 4'b1111;

    //             rst st ak ok      adv en       rdy flt fr  state
    // Power-up, settle-window glitch ignored, RUN, rail 2 fault and staged shutdown
    vecs.push_back(mk(1, 0, 0, 4'b1111, 2, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 7, 4'b0001, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0011, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8, 4'b0111, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8, 4'b1111, 0, 0, 0, ST_SETTLE));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 5, 4'b1111, 0, 0, 0, ST_SETTLE));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 10, 4'b1111, 0, 0, 0, ST_SETTLE));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 3, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 4'b0111, 0, 1, 2, ST_SHUTDOWN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 7, 4'b0111, 0, 1, 2, ST_SHUTDOWN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0011, 0, 1, 2, ST_SHUTDOWN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8, 4'b0001, 0, 1, 2, ST_SHUTDOWN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8, 4'b0000, 0, 1, 2, ST_FAULT));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 5, 4'b0000, 0, 1, 2, ST_FAULT));
    vecs.push_back(mk(0, 0, 1, 4'b1111, 1, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 3, 4'b0000, 0, 0, 0, ST_OFF));
    // Power-down request mid-ramp
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 8, 4'b0011, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 3, 4'b0011, 0, 0, 0, ST_RAMP));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, ST_SHUTDOWN));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 7, 4'b0001, 0, 0, 0, ST_SHUTDOWN));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 0, 1, 4'b1111, 2, 4'b0000, 0, 0, 0, ST_OFF));
    // Fault beats simultaneous start=0; ack ignored in RUN; start ignored in SHUTDOWN
    vecs.push_back(mk(0, 1, 0, 4'b1111, 41, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 2, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 0, 0, 4'b1110, 1, 4'b0111, 0, 1, 0, ST_SHUTDOWN));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 24, 4'b0000, 0, 1, 0, ST_FAULT));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 1, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, ST_RAMP));
    // Reset in RUN, then lowest failing index among several
    vecs.push_back(mk(0, 1, 0, 4'b1111, 40, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 2, 4'b0000, 0, 0, 0, ST_OFF));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 41, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 1, 0, 4'b0101, 1, 4'b0111, 0, 1, 1, ST_SHUTDOWN));
    vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, ST_OFF));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; ack = vecs[i].ak; rail_ok = vecs[i].ok;
      repeat (vecs[i].adv) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].en, vecs[i].rdy, vecs[i].flt, vecs[i].frail, vecs[i].sta);
    end

`ifdef PWR_SEQ_AUTO_RETRY_EN
    begin
      int restarts;
      logic [2:0] prev;
      reset = 1'b0; ack = 1'b0; start = 1'b1; rail_ok = 4'b1101;
      restarts = 0;
      prev = state;
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        if (prev == ST_FAULT && state == ST_OFF) restarts++;
        prev = state;
      end
      checks++;
      if (restarts != 3) begin
        errors++;
        $display("FAIL retry_count: got %0d restarts, want 3", restarts);
      end
      check("retry_exhausted", 4'b0000, 0, 1, 1, ST_FAULT);
      start = 1'b0; ack = 1'b1;
      @(posedge clk); #1;
      check("retry_ack", 4'b0000, 0, 0, 0, ST_OFF);
      ack = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
